// File: rtl/mapa_pkg.sv
// Shared definitions for the game map RAM arbiter:
// cell encodings, default dimensions and requester IDs.
package mapa_pkg;

   typedef enum logic [1:0] {
      VAZIO     = 2'b00,
      COBRA     = 2'b01,
      FRUTA     = 2'b10,
      OBSTACULO = 2'b11
   } cell_t;

   typedef enum logic [1:0] {
      REQ_VGA   = 2'd0,
      REQ_UPD   = 2'd1,
      REQ_SPAWN = 2'd2
   } req_id_t;

   localparam int MAPA_WIDTH_DEF   = 40;
   localparam int MAPA_HEIGHT_DEF  = 30;
   localparam int ADDR_W_DEF       = 11;
   localparam int STARVE_LIMIT_DEF = 15;

endpackage

// File: rtl/mapa_arbiter_if.sv
// Requester and RAM-side signal bundle of the map arbiter.
interface mapa_arbiter_if #(
   parameter int ADDR_W = 11
);
   logic              vga_req;
   logic [9:0]        vga_x;
   logic [9:0]        vga_y;
   logic              vga_gnt;
   logic [1:0]        vga_rdata;
   logic              vga_rvalid;
   logic              upd_req;
   logic              upd_we;
   logic [9:0]        upd_x;
   logic [9:0]        upd_y;
   logic [1:0]        upd_wdata;
   logic              upd_gnt;
   logic [1:0]        upd_rdata;
   logic              upd_rvalid;
   logic              spawn_req;
   logic [9:0]        spawn_x;
   logic [9:0]        spawn_y;
   logic [1:0]        spawn_wdata;
   logic              spawn_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [1:0]        mem_wdata;
   logic [1:0]        mem_rdata;

   modport slave (
      input  vga_req, vga_x, vga_y,
      input  upd_req, upd_we, upd_x, upd_y, upd_wdata,
      input  spawn_req, spawn_x, spawn_y, spawn_wdata,
      input  mem_rdata,
      output vga_gnt, vga_rdata, vga_rvalid,
      output upd_gnt, upd_rdata, upd_rvalid,
      output spawn_gnt,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vga_req, vga_x, vga_y,
      output upd_req, upd_we, upd_x, upd_y, upd_wdata,
      output spawn_req, spawn_x, spawn_y, spawn_wdata,
      output mem_rdata,
      input  vga_gnt, vga_rdata, vga_rvalid,
      input  upd_gnt, upd_rdata, upd_rvalid,
      input  spawn_gnt,
      input  mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/mapa_addr_calc.sv
// Cell coordinate to linear RAM address, with range flag.
module mapa_addr_calc #(
   parameter int MAPA_WIDTH  = 40,
   parameter int MAPA_HEIGHT = 30,
   parameter int ADDR_W      = 11
) (
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   always_comb begin
      in_range = (int'(x) < MAPA_WIDTH) && (int'(y) < MAPA_HEIGHT);
      addr     = in_range ? ADDR_W'(int'(y) * MAPA_WIDTH + int'(x)) : '0;
   end
endmodule

// File: rtl/mapa_arbiter.sv
// Single-port map RAM arbiter: VGA, update FSM and spawner,
// with starvation override and tagged read return.
module mapa_arbiter
   import mapa_pkg::*;
#(
   parameter int MAPA_WIDTH   = MAPA_WIDTH_DEF,
   parameter int MAPA_HEIGHT  = MAPA_HEIGHT_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input logic          clk,
   input logic          reset,
   mapa_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   logic [ADDR_W-1:0] vga_addr, upd_addr, spawn_addr;
   logic              vga_in, upd_in, spawn_in;

   mapa_addr_calc #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT),
      .ADDR_W(ADDR_W)) u_vga_ac (
      .x(bus.vga_x), .y(bus.vga_y), .addr(vga_addr), .in_range(vga_in));
   mapa_addr_calc #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT),
      .ADDR_W(ADDR_W)) u_upd_ac (
      .x(bus.upd_x), .y(bus.upd_y), .addr(upd_addr), .in_range(upd_in));
   mapa_addr_calc #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT),
      .ADDR_W(ADDR_W)) u_spawn_ac (
      .x(bus.spawn_x), .y(bus.spawn_y), .addr(spawn_addr),
      .in_range(spawn_in));

   req_id_t           ptr, ptr_n;
   logic [CW-1:0]     upd_cnt, upd_cnt_n, spawn_cnt, spawn_cnt_n;
   logic              win_vga, win_upd, win_spawn, win_any;
   logic              upd_st, spawn_st;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we, sel_rd, sel_oor;
   logic [1:0]        sel_wdata;
   req_id_t           sel_id;

   logic              gnt_vga, gnt_upd, gnt_spawn;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        wdata_q;
   logic              acc_rd, acc_oor;
   req_id_t           acc_id;
   logic              tag_v, tag_oor;
   req_id_t           tag_id;

   assign upd_st   = bus.upd_req && (upd_cnt == LIM);
   assign spawn_st = bus.spawn_req && (spawn_cnt == LIM);

   always_comb begin
      win_vga   = 1'b0;
      win_upd   = 1'b0;
      win_spawn = 1'b0;
      if (upd_st && spawn_st) begin
         win_upd   = (ptr == REQ_UPD);
         win_spawn = (ptr != REQ_UPD);
      end else if (upd_st) begin
         win_upd = 1'b1;
      end else if (spawn_st) begin
         win_spawn = 1'b1;
      end else if (bus.vga_req) begin
         win_vga = 1'b1;
      end else if (bus.upd_req && bus.spawn_req) begin
         win_upd   = (ptr == REQ_UPD);
         win_spawn = (ptr != REQ_UPD);
      end else begin
         win_upd   = bus.upd_req;
         win_spawn = bus.spawn_req;
      end
      win_any = win_vga | win_upd | win_spawn;
   end

   // Pointer flips to the other non-VGA requester after serving either
   always_comb begin
      ptr_n = ptr;
      if (win_upd)   ptr_n = REQ_SPAWN;
      if (win_spawn) ptr_n = REQ_UPD;
      upd_cnt_n = (!bus.upd_req || win_upd) ? '0 :
                  (upd_cnt == LIM) ? upd_cnt : upd_cnt + 1'b1;
      spawn_cnt_n = (!bus.spawn_req || win_spawn) ? '0 :
                    (spawn_cnt == LIM) ? spawn_cnt : spawn_cnt + 1'b1;
   end

   always_comb begin
      sel_addr  = vga_addr;
      sel_we    = 1'b0;
      sel_wdata = 2'b00;
      sel_rd    = 1'b1;
      sel_oor   = !vga_in;
      sel_id    = REQ_VGA;
      unique case (1'b1)
         win_upd: begin
            sel_addr  = upd_addr;
            sel_we    = bus.upd_we && upd_in;
            sel_wdata = bus.upd_wdata;
            sel_rd    = !bus.upd_we;
            sel_oor   = !upd_in;
            sel_id    = REQ_UPD;
         end
         win_spawn: begin
            sel_addr  = spawn_addr;
            sel_we    = spawn_in;
            sel_wdata = bus.spawn_wdata;
            sel_rd    = 1'b0;
            sel_oor   = !spawn_in;
            sel_id    = REQ_SPAWN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= REQ_UPD;
         upd_cnt   <= '0;
         spawn_cnt <= '0;
         gnt_vga   <= 1'b0;
         gnt_upd   <= 1'b0;
         gnt_spawn <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= 2'b00;
         acc_rd    <= 1'b0;
         acc_oor   <= 1'b0;
         acc_id    <= REQ_VGA;
         tag_v     <= 1'b0;
         tag_oor   <= 1'b0;
         tag_id    <= REQ_VGA;
      end else begin
         ptr       <= ptr_n;
         upd_cnt   <= upd_cnt_n;
         spawn_cnt <= spawn_cnt_n;
         gnt_vga   <= win_vga;
         gnt_upd   <= win_upd;
         gnt_spawn <= win_spawn;
         we_q      <= win_any && sel_we;
         if (win_any) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         acc_rd    <= win_any && sel_rd;
         acc_oor   <= sel_oor;
         acc_id    <= sel_id;
         tag_v     <= acc_rd;
         tag_oor   <= acc_oor;
         tag_id    <= acc_id;
      end
   end

   logic [1:0] rd;

   // Reset kills a read returning in the same cycle
   always_comb begin
      rd             = tag_oor ? OBSTACULO : bus.mem_rdata;
      bus.vga_rvalid = tag_v && !reset && (tag_id == REQ_VGA);
      bus.upd_rvalid = tag_v && !reset && (tag_id == REQ_UPD);
      bus.vga_rdata  = bus.vga_rvalid ? rd : 2'b00;
      bus.upd_rdata  = bus.upd_rvalid ? rd : 2'b00;
      bus.vga_gnt    = gnt_vga;
      bus.upd_gnt    = gnt_upd;
      bus.spawn_gnt  = gnt_spawn;
      bus.mem_addr   = addr_q;
      bus.mem_we     = we_q;
      bus.mem_wdata  = wdata_q;
   end
endmodule

// File: tb/tb_mapa_arbiter.sv
// Directed self-checking bench for mapa_arbiter with a
// synchronous RAM model attached to the memory port.
module tb_mapa_arbiter;
   import mapa_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total = 0;

   always #5 clk = ~clk;

   mapa_arbiter_if #(.ADDR_W(11)) bus ();

   mapa_arbiter #(
      .MAPA_WIDTH(40), .MAPA_HEIGHT(30), .ADDR_W(11), .STARVE_LIMIT(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   logic [1:0] ram [0:2047];
   logic [1:0] rdq;

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      rdq <= ram[bus.mem_addr];
   end
   assign bus.mem_rdata = rdq;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.vga_req   = 1'b0;
      bus.upd_req   = 1'b0;
      bus.spawn_req = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({bus.vga_gnt, bus.upd_gnt, bus.spawn_gnt, bus.vga_rvalid,
           bus.upd_rvalid, bus.mem_we} !== 6'b0)
         $display("FAIL reset_flags got %b exp 000000",
            {bus.vga_gnt, bus.upd_gnt, bus.spawn_gnt, bus.vga_rvalid,
             bus.upd_rvalid, bus.mem_we});
      else passed++;
      total++;
      if ({bus.mem_addr, bus.mem_wdata, bus.vga_rdata, bus.upd_rdata} !== 17'b0)
         $display("FAIL reset_data got %h exp 0",
            {bus.mem_addr, bus.mem_wdata, bus.vga_rdata, bus.upd_rdata});
      else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_round_robin;
      logic [1:0] exp [4];
      exp[0] = 2'b10; exp[1] = 2'b01; exp[2] = 2'b10; exp[3] = 2'b01;
      bus.upd_req = 1'b1; bus.upd_we = 1'b0;
      bus.upd_x = 10'd0; bus.upd_y = 10'd0;
      bus.spawn_req = 1'b1; bus.spawn_x = 10'd1; bus.spawn_y = 10'd0;
      bus.spawn_wdata = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({bus.upd_gnt, bus.spawn_gnt} !== exp[i])
            $display("FAIL rr_grant%0d got %b exp %b", i,
               {bus.upd_gnt, bus.spawn_gnt}, exp[i]);
         else passed++;
      end
      idle();
      tick(); tick(); tick();
   endtask

   task automatic test_upd_write;
      bus.upd_req = 1'b1; bus.upd_we = 1'b1;
      bus.upd_x = 10'd10; bus.upd_y = 10'd10; bus.upd_wdata = 2'b01;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
          {1'b1, 1'b1, 11'd410, 2'b01})
         $display("FAIL wr_grant got gnt=%b we=%b addr=%0d wd=%b exp 1 1 410 01",
            bus.upd_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      else passed++;
      bus.upd_req = 1'b0;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr} !== {1'b0, 1'b0, 11'd410})
         $display("FAIL wr_after got gnt=%b we=%b addr=%0d exp 0 0 410",
            bus.upd_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
   endtask

   task automatic test_upd_read;
      bus.upd_req = 1'b1; bus.upd_we = 1'b0;
      bus.upd_x = 10'd10; bus.upd_y = 10'd10;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 11'd410})
         $display("FAIL rd_grant got gnt=%b we=%b addr=%0d exp 1 0 410",
            bus.upd_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.upd_req = 1'b0;
      tick();
      total++;
      if ({bus.upd_rvalid, bus.upd_rdata, bus.vga_rvalid} !== 4'b1010)
         $display("FAIL rd_data got rv=%b rd=%b vrv=%b exp 1 01 0",
            bus.upd_rvalid, bus.upd_rdata, bus.vga_rvalid);
      else passed++;
      tick();
      total++;
      if (bus.upd_rvalid !== 1'b0)
         $display("FAIL rd_pulse got %b exp 0", bus.upd_rvalid);
      else passed++;
   endtask

   task automatic test_back_to_back;
      bus.upd_req = 1'b1; bus.upd_we = 1'b1;
      bus.upd_x = 10'd5; bus.upd_y = 10'd2; bus.upd_wdata = 2'b10;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 11'd85})
         $display("FAIL b2b_wr got gnt=%b we=%b addr=%0d exp 1 1 85",
            bus.upd_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.upd_we = 1'b0;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 11'd85})
         $display("FAIL b2b_rd got gnt=%b we=%b addr=%0d exp 1 0 85",
            bus.upd_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.upd_req = 1'b0;
      tick();
      total++;
      if ({bus.upd_rvalid, bus.upd_rdata} !== 3'b110)
         $display("FAIL b2b_data got rv=%b rd=%b exp 1 10",
            bus.upd_rvalid, bus.upd_rdata);
      else passed++;
      tick();
   endtask

   task automatic test_starve;
      bus.vga_req = 1'b1; bus.vga_x = 10'd1; bus.vga_y = 10'd0;
      bus.upd_req = 1'b1; bus.upd_we = 1'b0;
      bus.upd_x = 10'd3; bus.upd_y = 10'd0;
      for (int i = 0; i < 15; i++) begin
         tick();
         total++;
         if ({bus.vga_gnt, bus.upd_gnt} !== 2'b10)
            $display("FAIL starve_vga%0d got %b exp 10", i,
               {bus.vga_gnt, bus.upd_gnt});
         else passed++;
      end
      tick();
      total++;
      if ({bus.vga_gnt, bus.upd_gnt} !== 2'b01)
         $display("FAIL starve_upd got %b exp 01", {bus.vga_gnt, bus.upd_gnt});
      else passed++;
      bus.upd_req = 1'b0;
      tick();
      total++;
      if ({bus.vga_gnt, bus.upd_gnt} !== 2'b10)
         $display("FAIL starve_resume got %b exp 10", {bus.vga_gnt, bus.upd_gnt});
      else passed++;
      idle();
      tick(); tick(); tick();
   endtask

   task automatic test_out_of_range;
      bus.upd_req = 1'b1; bus.upd_we = 1'b0;
      bus.upd_x = 10'd40; bus.upd_y = 10'd5;
      tick();
      total++;
      if ({bus.upd_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 11'd0})
         $display("FAIL oor_rd_grant got gnt=%b we=%b addr=%0d exp 1 0 0",
            bus.upd_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.upd_req = 1'b0;
      tick();
      total++;
      if ({bus.upd_rvalid, bus.upd_rdata} !== 3'b111)
         $display("FAIL oor_rd_data got rv=%b rd=%b exp 1 11",
            bus.upd_rvalid, bus.upd_rdata);
      else passed++;
      bus.spawn_req = 1'b1; bus.spawn_x = 10'd3;
      bus.spawn_y = 10'd30; bus.spawn_wdata = 2'b10;
      tick();
      total++;
      if ({bus.spawn_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 11'd0})
         $display("FAIL oor_wr got gnt=%b we=%b addr=%0d exp 1 0 0",
            bus.spawn_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.spawn_req = 1'b0;
      tick();
      total++;
      if ({bus.upd_rvalid, bus.vga_rvalid} !== 2'b00)
         $display("FAIL oor_wr_norv got %b exp 00",
            {bus.upd_rvalid, bus.vga_rvalid});
      else passed++;
   endtask

   task automatic test_vga_read;
      bus.spawn_req = 1'b1; bus.spawn_x = 10'd39;
      bus.spawn_y = 10'd29; bus.spawn_wdata = 2'b10;
      tick();
      total++;
      if ({bus.spawn_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 11'd1199})
         $display("FAIL corner_wr got gnt=%b we=%b addr=%0d exp 1 1 1199",
            bus.spawn_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.spawn_req = 1'b0;
      bus.vga_req = 1'b1; bus.vga_x = 10'd39; bus.vga_y = 10'd29;
      tick();
      total++;
      if ({bus.vga_gnt, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 11'd1199})
         $display("FAIL vga_grant got gnt=%b we=%b addr=%0d exp 1 0 1199",
            bus.vga_gnt, bus.mem_we, bus.mem_addr);
      else passed++;
      bus.vga_req = 1'b0;
      tick();
      total++;
      if ({bus.vga_rvalid, bus.vga_rdata, bus.upd_rvalid} !== 4'b1100)
         $display("FAIL vga_data got rv=%b rd=%b urv=%b exp 1 10 0",
            bus.vga_rvalid, bus.vga_rdata, bus.upd_rvalid);
      else passed++;
      tick();
   endtask

   task automatic test_reset_midop;
      bus.vga_req = 1'b1; bus.vga_x = 10'd10; bus.vga_y = 10'd10;
      tick();
      total++;
      if (bus.vga_gnt !== 1'b1)
         $display("FAIL midrst_grant got %b exp 1", bus.vga_gnt);
      else passed++;
      bus.vga_req = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      total++;
      if (bus.vga_rvalid !== 1'b0)
         $display("FAIL midrst_norv got %b exp 0", bus.vga_rvalid);
      else passed++;
      tick();
      total++;
      if ({bus.vga_gnt, bus.upd_gnt, bus.spawn_gnt, bus.vga_rvalid,
           bus.upd_rvalid, bus.mem_we, bus.mem_addr, bus.mem_wdata,
           bus.vga_rdata, bus.upd_rdata} !== 23'b0)
         $display("FAIL midrst_outs got %h exp 0",
            {bus.vga_gnt, bus.upd_gnt, bus.spawn_gnt, bus.vga_rvalid,
             bus.upd_rvalid, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.vga_rdata, bus.upd_rdata});
      else passed++;
      reset = 1'b0;
      tick();
      total++;
      if (bus.vga_rvalid !== 1'b0)
         $display("FAIL midrst_late got %b exp 0", bus.vga_rvalid);
      else passed++;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = 2'b00;
      idle();
      bus.vga_x = '0; bus.vga_y = '0;
      bus.upd_we = 1'b0; bus.upd_x = '0; bus.upd_y = '0;
      bus.upd_wdata = '0;
      bus.spawn_x = '0; bus.spawn_y = '0; bus.spawn_wdata = '0;
      test_reset();
      test_round_robin();
      test_upd_write();
      test_upd_read();
      test_back_to_back();
      test_starve();
      test_out_of_range();
      test_vga_read();
      test_reset_midop();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
- Single-port arbiter in front of the 2-bit-per-cell game map RAM (MAPA_WIDTH x MAPA_HEIGHT).
- Shares the RAM between three requesters:
  - VGA renderer: read only.
  - Game update FSM: read or write.
  - Fruit/obstacle spawner: write only.
- Converts (x,y) to a linear address, issues one access per cycle and returns read data tagged to its requester.
- Sits between the map RAM and update / vga / spawn logic.

Parameters:
- MAPA_WIDTH, 40, map columns.
- MAPA_HEIGHT, 30, map rows.
- ADDR_W, 11, RAM address width (must hold MAPA_WIDTH*MAPA_HEIGHT-1).
- STARVE_LIMIT, 15, cycles a pending non-VGA request may wait before it overrides VGA priority.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vga_req  in  1  VGA read request
- vga_x  in  10  VGA cell column
- vga_y  in  10  VGA cell row
- vga_gnt  out  1  VGA request accepted (1-cycle pulse)
- vga_rdata  out  2  VGA read data
- vga_rvalid  out  1  vga_rdata valid (1-cycle pulse)
- upd_req  in  1  update request
- upd_we  in  1  1 = write, 0 = read
- upd_x  in  10  update cell column
- upd_y  in  10  update cell row
- upd_wdata  in  2  update write data
- upd_gnt  out  1  update request accepted
- upd_rdata  out  2  update read data
- upd_rvalid  out  1  upd_rdata valid
- spawn_req  in  1  spawner write request
- spawn_x  in  10  spawner cell column
- spawn_y  in  10  spawner cell row
- spawn_wdata  in  2  spawner write data
- spawn_gnt  out  1  spawner request accepted
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  2  RAM write data
- mem_rdata  in  2  RAM read data; synchronous RAM, valid 1 cycle after mem_addr

Behaviour:
- Reset values:
  - All *_gnt, *_rvalid and mem_we = 0.
  - mem_addr, mem_wdata, all *_rdata = 0.
  - Round-robin pointer = upd.
  - Starvation counters = 0.
  - In-flight read tags cleared.
- Reset asserted mid-operation: any in-flight read is dropped and no rvalid is produced for it.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt.
  - Each gnt is a 1-cycle pulse.
  - Req may drop the cycle after gnt or stay high to issue back-to-back requests.
- Arbitration (registered): requests sampled at edge N.
  - Winner's gnt, mem_addr, mem_we and mem_wdata are driven from edge N, i.e. during cycle N+1.
  - At most one grant per cycle.
- Priority:
  1. Starved requester: upd or spawn whose starvation counter has reached STARVE_LIMIT. If both are starved, the round-robin pointer decides.
  2. VGA.
  3. upd and spawn, round-robin. The pointer moves to the other requester after each grant to either.
- Starvation counters:
  - One per non-VGA requester.
  - Increments each cycle its req is high without gnt, saturating at STARVE_LIMIT.
  - Clears on its gnt or when req is low.
- Read latency: gnt at cycle N+1, then *_rdata plus a 1-cycle *_rvalid at cycle N+2. The requester ID travels in a 1-deep tag pipeline.
- Write: mem_we = 1 for exactly the grant cycle. No rvalid is produced.
- Ordering: accesses hit the RAM in grant order. A read granted after a write to the same cell returns the new value.
- Address calculation: mem_addr = y*MAPA_WIDTH + x.
- Out-of-range coordinates (x >= MAPA_WIDTH or y >= MAPA_HEIGHT):
  - Still granted; mem_we forced to 0; mem_addr = 0.
  - Read returns 2'b11 (obstacle) with normal latency, so update logic treats it as a collision.
- No requests: mem_we = 0 and mem_addr holds its last value.

Decomposition:
- Package mapa_pkg holds:
  - Cell encodings: VAZIO=2'b00, COBRA=2'b01, FRUTA=2'b10, OBSTACULO=2'b11.
  - Default map dimensions.
  - Requester IDs: REQ_VGA, REQ_UPD, REQ_SPAWN.
- One sub-module, mapa_addr_calc: combinational (x,y) -> addr plus in_range flag.
- Arbiter FSM, counters and tag pipeline stay in mapa_arbiter.

Test Plan:
- Reset, then single upd write (x=10, y=10, wdata=01) -> upd_gnt one cycle later; mem_addr=410, mem_we=1, mem_wdata=01 for that cycle only.
- upd read at (10,10) right after that write -> upd_rvalid one cycle after upd_gnt with upd_rdata=01; vga_rvalid stays 0.
- vga_req held high continuously while upd_req is also high -> VGA granted every cycle until the upd counter reaches 15; upd is granted on the next arbitration; VGA resumes after.
- upd_req and spawn_req both high, no VGA -> grants alternate upd, spawn, upd, spawn; pointer starts at upd after reset.
- upd read at x=40, y=5 -> granted, mem_we=0, upd_rdata=11, upd_rvalid one cycle after gnt. spawn write at y=30 -> no RAM write.
- vga read granted, reset asserted the cycle after gnt -> no vga_rvalid; all outputs at reset values on the next cycle.
